instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/pc_next_sel.sv | 39 +++
 rtl/instr_fetch_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the instruction fetch slice:
//   - next-PC select encodings driven by the control unit (srcPC)
//   - fetch FSM state enumeration
//   - canonical NOP instruction (addi x0, x0, 0) loaded into inst on reset
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [1:0] PC_SEQ  = 2'b00;   // pc + 4
    localparam logic [1:0] PC_BR   = 2'b01;   // br_target if take_branch, else pc + 4
    localparam logic [1:0] PC_JALR = 2'b10;   // jalr_target with bit 0 cleared
    localparam logic [1:0] PC_TRAP = 2'b11;   // trap vector (ecall / fence)

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_VALID = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// -----------------------------------------------------------------------------
// pc_next_sel
// Purely combinational next-PC selector.
// Ports:
//   pc_i          current instruction address
//   src_pc_i      next-PC select (PC_SEQ / PC_BR / PC_JALR / PC_TRAP)
//   take_branch_i branch condition true (only meaningful for PC_BR)
//   br_target_i   pc + imm target for branches and jal
//   jalr_target_i ALU result for jalr
//   next_pc_o     raw selected next PC (alignment handled by the caller)
//   pc_plus4_o    pc_i + 4, modulo 2^32
// -----------------------------------------------------------------------------
module pc_next_sel
    import riscv_pkg::*;
#(
    parameter logic [31:0] TRAP_VEC = 32'h0000_0004
) (
    input  logic [31:0] pc_i,
    input  logic [1:0]  src_pc_i,
    input  logic        take_branch_i,
    input  logic [31:0] br_target_i,
    input  logic [31:0] jalr_target_i,
    output logic [31:0] next_pc_o,
    output logic [31:0] pc_plus4_o
);

    always_comb begin
        pc_plus4_o = pc_i + 32'd4;
        next_pc_o  = pc_plus4_o;
        case (src_pc_i)
            PC_SEQ:  next_pc_o = pc_plus4_o;
            PC_BR:   next_pc_o = take_branch_i ? br_target_i : pc_plus4_o;
            // jalr clears the LSB of the computed target
            PC_JALR: next_pc_o = jalr_target_i & 32'hFFFF_FFFE;
            default: next_pc_o = TRAP_VEC;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Non-pipelined instruction fetch: requests one word, waits for it, holds it
// for the core until accepted, then fetches from the selected next PC.
// Optional feature macro: FETCH_MISALIGN_CHK_EN
//   defined   : a misaligned next PC is not fetched; the unit halts and raises
//               the sticky fetch_misalign output
//   undefined : next PC bits [1:0] are forced to zero, no fetch_misalign port
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   imem_req/imem_addr/imem_gnt    request channel to instruction memory
//   imem_rvalid/imem_rdata         response channel from instruction memory
//   inst_valid/inst_ready          handshake with the core
//   inst, pc, pc_plus4             held instruction, its address, address + 4
//   srcPC, pcload, take_branch     control unit next-PC controls (sampled on accept)
//   br_target, jalr_target         next-PC candidates
//   halted                         fetch stopped until reset
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic [1:0]  srcPC,
    input  logic        pcload,
    input  logic        take_branch,
    input  logic [31:0] br_target,
    input  logic [31:0] jalr_target,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic        fetch_misalign,
`endif
    output logic        halted
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q;
    logic [31:0]  pc_q;
    logic [31:0]  inst_q;
    logic [31:0]  next_pc_raw;
    logic [31:0]  next_pc_cand;
    logic         next_misaligned;
    logic         accept;

    pc_next_sel #(
        .TRAP_VEC (TRAP_VEC)
    ) u_pc_next_sel (
        .pc_i          (pc_q),
        .src_pc_i      (srcPC),
        .take_branch_i (take_branch),
        .br_target_i   (br_target),
        .jalr_target_i (jalr_target),
        .next_pc_o     (next_pc_raw),
        .pc_plus4_o    (pc_plus4)
    );

    assign accept = (state_q == ST_VALID) && inst_ready;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_q;
    assign next_misaligned = (next_pc_raw[1:0] != 2'b00);
    assign next_pc_cand    = next_pc_raw;
`else
    assign next_misaligned = 1'b0;
    assign next_pc_cand    = next_pc_raw & 32'hFFFF_FFFC;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_REQ;
            ST_REQ:   if (imem_gnt)    state_d = ST_WAIT;
            // a response seen in any other state is simply dropped
            ST_WAIT:  if (imem_rvalid) state_d = ST_VALID;
            ST_VALID: begin
                if (inst_ready) begin
                    state_d = (!pcload || next_misaligned) ? ST_HALT : ST_REQ;
                end
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req   = (state_q == ST_REQ);
        inst_valid = (state_q == ST_VALID);
        halted     = (state_q == ST_HALT);
        imem_addr  = fetch_pc_q;
        inst       = inst_q;
        pc         = pc_q;
    end

    // Datapath: fetch address, held instruction and its address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            pc_q       <= RESET_PC;
            inst_q     <= NOP_INST;
        end else begin
            if ((state_q == ST_WAIT) && imem_rvalid) begin
                inst_q <= imem_rdata;
                pc_q   <= fetch_pc_q;
            end
            // a halting accept (pcload=0) or a rejected target leaves fetch_pc alone
            if (accept && pcload && !next_misaligned) begin
                fetch_pc_q <= next_pc_cand;
            end
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (accept && pcload && next_misaligned) begin
            misalign_q <= 1'b1;
        end
    end
    assign fetch_misalign = misalign_q;
`endif

endmodule
